// File: rtl/axi_read_arbiter_pkg.sv
// Shared constants and types for the m00 AXI read-channel arbiter.
// Encodings are reused by the write-side arbiter.
package axi_read_arbiter_pkg;

    localparam logic [2:0] AXI_SIZE_64B   = 3'd6;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2
    } arb_state_e;

    localparam int unsigned REQ_FEATURE = 0;
    localparam int unsigned REQ_WEIGHT  = 1;
    localparam int unsigned REQ_PARAM   = 2;

    // Index width that stays legal for a single client.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational circular first-one finder: the first set request at or after ptr,
// wrapping from NUM_REQ-1 back to 0.
module rr_priority_pick
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               found
);

    logic [NUM_REQ-1:0] req_rot;

    // Rotate so that bit 0 is the client the pointer names.
    assign req_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                found = 1'b1;
                grant = IDX_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing the m00 AXI4 read channel among NUM_REQ clients,
// one burst at a time; the grant is held from AR acceptance to the rlast beat.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                      system_clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_arlen,
    input  logic [NUM_REQ-1:0]        req_arvalid,
    output logic [NUM_REQ-1:0]        req_arready,
    output logic [DATA_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]        req_rvalid,
    output logic                      req_rlast,
    input  logic [NUM_REQ-1:0]        req_rready,
    output logic [ADDR_W-1:0]         m00_axi_araddr,
    output logic [LEN_W-1:0]          m00_axi_arlen,
    output logic [2:0]                m00_axi_arsize,
    output logic [1:0]                m00_axi_arburst,
    output logic                      m00_axi_arvalid,
    input  logic                      m00_axi_arready,
    input  logic [DATA_W-1:0]         m00_axi_rdata,
    input  logic [1:0]                m00_axi_rresp,
    input  logic                      m00_axi_rlast,
    input  logic                      m00_axi_rvalid,
    output logic                      m00_axi_rready,
    output logic                      busy,
    output logic                      rresp_err,
    output logic [LEN_W:0]            beat_cnt
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, grant_q, pick;
    logic               pick_found;
    logic [ADDR_W-1:0]  addr_q, sel_addr;
    logic [LEN_W-1:0]   len_q, sel_len;
    logic [LEN_W:0]     beat_cnt_q;
    logic               rresp_err_q;
    logic [NUM_REQ-1:0] grant_oh;
    logic               ar_hs, r_hs;

    rr_priority_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req  (req_arvalid),
        .ptr  (ptr_q),
        .grant(pick),
        .found(pick_found)
    );

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_addr = req_araddr[i*ADDR_W +: ADDR_W];
                sel_len  = req_arlen[i*LEN_W +: LEN_W];
            end
        end
    end

    assign grant_oh = NUM_REQ'(1) << grant_q;
    assign ar_hs    = (state_q == StAddr) && m00_axi_arready;
    assign r_hs     = (state_q == StData) && m00_axi_rvalid && (|(req_rready & grant_oh));

    always_ff @(posedge system_clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            rresp_err_q <= 1'b0;
        end else begin
            if (state_q == StIdle && pick_found) begin
                grant_q <= pick;
                addr_q  <= sel_addr;
                len_q   <= sel_len;
            end
            if (ar_hs) begin
                beat_cnt_q <= '0;
            end
            if (r_hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
                if (m00_axi_rresp != 2'b00) begin
                    rresp_err_q <= 1'b1;
                end
                // Next arbitration starts just past the client that was served.
                if (m00_axi_rlast) begin
                    ptr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pick_found) state_d = StAddr;
            StAddr:  if (m00_axi_arready) state_d = StData;
            StData:  if (r_hs && m00_axi_rlast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m00_axi_arvalid = 1'b0;
        req_arready     = '0;
        m00_axi_rready  = 1'b0;
        req_rvalid      = '0;
        req_rdata       = '0;
        req_rlast       = 1'b0;
        unique case (state_q)
            StAddr: begin
                m00_axi_arvalid = 1'b1;
                if (m00_axi_arready) req_arready = grant_oh;
            end
            StData: begin
                m00_axi_rready = |(req_rready & grant_oh);
                req_rvalid     = m00_axi_rvalid ? grant_oh : '0;
                req_rdata      = m00_axi_rdata;
                req_rlast      = m00_axi_rlast;
            end
            default: ;
        endcase
    end

    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arlen   = len_q;
    assign m00_axi_arsize  = AXI_SIZE_64B;
    assign m00_axi_arburst = AXI_BURST_INCR;
    assign busy            = (state_q != StIdle);
    assign rresp_err       = rresp_err_q;
    assign beat_cnt        = beat_cnt_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: client/slave models driven per cycle,
// a transaction-level reference checked every cycle, directed tables and random traffic.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 512;
    localparam int LEN_W   = 8;

    logic                      system_clk;
    logic                      rst;
    logic [NUM_REQ*ADDR_W-1:0] req_araddr;
    logic [NUM_REQ*LEN_W-1:0]  req_arlen;
    logic [NUM_REQ-1:0]        req_arvalid;
    logic [NUM_REQ-1:0]        req_arready;
    logic [DATA_W-1:0]         req_rdata;
    logic [NUM_REQ-1:0]        req_rvalid;
    logic                      req_rlast;
    logic [NUM_REQ-1:0]        req_rready;
    logic [ADDR_W-1:0]         m00_axi_araddr;
    logic [LEN_W-1:0]          m00_axi_arlen;
    logic [2:0]                m00_axi_arsize;
    logic [1:0]                m00_axi_arburst;
    logic                      m00_axi_arvalid;
    logic                      m00_axi_arready;
    logic [DATA_W-1:0]         m00_axi_rdata;
    logic [1:0]                m00_axi_rresp;
    logic                      m00_axi_rlast;
    logic                      m00_axi_rvalid;
    logic                      m00_axi_rready;
    logic                      busy;
    logic                      rresp_err;
    logic [LEN_W:0]            beat_cnt;

    axi_read_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .system_clk     (system_clk),
        .rst            (rst),
        .req_araddr     (req_araddr),
        .req_arlen      (req_arlen),
        .req_arvalid    (req_arvalid),
        .req_arready    (req_arready),
        .req_rdata      (req_rdata),
        .req_rvalid     (req_rvalid),
        .req_rlast      (req_rlast),
        .req_rready     (req_rready),
        .m00_axi_araddr (m00_axi_araddr),
        .m00_axi_arlen  (m00_axi_arlen),
        .m00_axi_arsize (m00_axi_arsize),
        .m00_axi_arburst(m00_axi_arburst),
        .m00_axi_arvalid(m00_axi_arvalid),
        .m00_axi_arready(m00_axi_arready),
        .m00_axi_rdata  (m00_axi_rdata),
        .m00_axi_rresp  (m00_axi_rresp),
        .m00_axi_rlast  (m00_axi_rlast),
        .m00_axi_rvalid (m00_axi_rvalid),
        .m00_axi_rready (m00_axi_rready),
        .busy           (busy),
        .rresp_err      (rresp_err),
        .beat_cnt       (beat_cnt)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bound_expired(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Contents of the slave memory: every 64-byte line is a function of its address.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) begin
            w[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(k) << 24);
        end
        return w;
    endfunction

    // Client side
    logic [NUM_REQ-1:0] cl_pending;
    logic [ADDR_W-1:0]  cl_addr  [NUM_REQ];
    logic [LEN_W-1:0]   cl_len   [NUM_REQ];
    int                 cl_rereq [NUM_REQ];
    int                 rr_mode  [NUM_REQ];
    int                 dlv      [NUM_REQ];
    logic [NUM_REQ-1:0] seen_arready;
    bit                 tog;
    bit                 rand_on;
    int                 issued, dut_bursts, obs_ar_wait;

    // Slave side
    int                 s_state, s_beat, s_wait, ar_stall, err_beat;
    bit                 rgap;
    logic [ADDR_W-1:0]  s_addr, seen_araddr;
    logic [LEN_W-1:0]   s_len, seen_arlen;
    bit                 seen_ar_hs, seen_r_hs, seen_arvalid;

    // Reference: one outstanding transaction, served clients logged in order.
    bit                 txn_active, ar_done, merr;
    int                 mgrant, mptr, mbeats;
    logic [ADDR_W-1:0]  maddr;
    logic [LEN_W-1:0]   mlen;
    int                 glog[$];

    task automatic pack_inputs();
        req_arvalid = cl_pending;
        for (int c = 0; c < NUM_REQ; c++) begin
            req_araddr[c*ADDR_W +: ADDR_W] = cl_addr[c];
            req_arlen[c*LEN_W +: LEN_W]    = cl_len[c];
        end
    endtask

    task automatic new_req(input int c, input logic [ADDR_W-1:0] a, input int len);
        cl_pending[c] = 1'b1;
        cl_addr[c]    = a;
        cl_len[c]     = LEN_W'(len);
        issued++;
        pack_inputs();
    endtask

    // Runs at the falling edge: checks outputs, then advances the reference to what
    // the coming rising edge must do.
    task automatic sample_and_check();
        logic [NUM_REQ-1:0] goh;
        logic               exp_rready;
        seen_ar_hs   = m00_axi_arvalid && m00_axi_arready;
        seen_r_hs    = m00_axi_rvalid && m00_axi_rready;
        seen_arvalid = m00_axi_arvalid;
        seen_araddr  = m00_axi_araddr;
        seen_arlen   = m00_axi_arlen;
        seen_arready = req_arready;
        if (rst) begin
            txn_active = 0; ar_done = 0; merr = 0; mptr = 0; mbeats = 0;
            seen_ar_hs = 0; seen_r_hs = 0; seen_arvalid = 0; seen_arready = '0;
            return;
        end
        for (int c = 0; c < NUM_REQ; c++) begin
            if (req_rvalid[c] && req_rready[c]) dlv[c]++;
        end
        if (|(req_rvalid & req_rready) && req_rlast) dut_bursts++;
        if (m00_axi_arvalid && !m00_axi_arready) obs_ar_wait++;

        goh        = txn_active ? (NUM_REQ'(1) << mgrant) : '0;
        exp_rready = ar_done ? req_rready[mgrant] : 1'b0;
        chk("busy", busy, txn_active);
        chk("beat_cnt", beat_cnt, mbeats);
        chk("rresp_err", rresp_err, merr);
        chk("arsize", m00_axi_arsize, 3'd6);
        chk("arburst", m00_axi_arburst, 2'b01);
        chk("arvalid", m00_axi_arvalid, txn_active && !ar_done);
        if (txn_active && !ar_done) begin
            chk("araddr", m00_axi_araddr, maddr);
            chk("arlen", m00_axi_arlen, mlen);
            chk("req_arready", req_arready, m00_axi_arready ? goh : '0);
        end else begin
            chk("req_arready idle", req_arready, 0);
        end
        chk("m00_rready", m00_axi_rready, exp_rready);
        chk("req_rvalid", req_rvalid, (ar_done && m00_axi_rvalid) ? goh : '0);
        if (ar_done && m00_axi_rvalid) begin
            chk("req_rdata", req_rdata, mem_word(maddr + ADDR_W'(64 * mbeats)));
            chk("req_rlast", req_rlast, mbeats == int'(mlen));
        end

        if (!txn_active) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                int c;
                c = (mptr + i) % NUM_REQ;
                if (!txn_active && req_arvalid[c]) begin
                    txn_active = 1; ar_done = 0; mgrant = c;
                    maddr = cl_addr[c]; mlen = cl_len[c];
                    glog.push_back(c);
                end
            end
        end else if (!ar_done) begin
            if (m00_axi_arready) begin
                ar_done = 1;
                mbeats  = 0;
            end
        end else if (m00_axi_rvalid && exp_rready) begin
            mbeats++;
            if (m00_axi_rresp != 2'b00) merr = 1;
            if (m00_axi_rlast) begin
                mptr = (mgrant + 1) % NUM_REQ;
                txn_active = 0;
                ar_done = 0;
            end
        end
    endtask

    // Runs just after the rising edge: advances slave and client behaviour.
    task automatic drive_next();
        if (rst) begin
            s_state = 0; s_wait = 0; s_beat = 0;
            m00_axi_arready = 1'b0;
            m00_axi_rvalid  = 1'b0;
            m00_axi_rlast   = 1'b0;
            m00_axi_rresp   = 2'b00;
            m00_axi_rdata   = {16{32'hDEAD_BEEF}};
        end else begin
            if (s_state == 1 && seen_r_hs) begin
                if (m00_axi_rlast) s_state = 0;
                else s_beat++;
            end
            if (s_state == 0 && seen_ar_hs) begin
                s_state = 1; s_addr = seen_araddr; s_len = seen_arlen;
                s_beat = 0; s_wait = 0;
            end else if (s_state == 0 && seen_arvalid) begin
                s_wait++;
            end
            if (rand_on) ar_stall = $urandom_range(0, 2);
            m00_axi_arready = (s_state == 0) && (s_wait >= ar_stall);
            if (s_state == 1) begin
                if (!m00_axi_rvalid || seen_r_hs) begin
                    m00_axi_rvalid = rgap ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                m00_axi_rdata = mem_word(s_addr + ADDR_W'(64 * s_beat));
                m00_axi_rlast = (s_beat == int'(s_len));
                m00_axi_rresp = (err_beat != 0 && s_beat + 1 == err_beat) ? 2'b10 : 2'b00;
            end else begin
                m00_axi_rvalid = 1'b0;
                m00_axi_rlast  = 1'b0;
                m00_axi_rresp  = 2'b00;
            end
        end
        tog = ~tog;
        for (int c = 0; c < NUM_REQ; c++) begin
            if (seen_arready[c]) begin
                if (cl_rereq[c] > 0) begin
                    cl_rereq[c]--;
                    cl_addr[c] = cl_addr[c] + 32'h0001_0000;
                    issued++;
                end else begin
                    cl_pending[c] = 1'b0;
                end
            end
            if (rand_on && !cl_pending[c] && $urandom_range(0, 7) == 0) begin
                new_req(c, $urandom & 32'hFFFF_FFC0, $urandom_range(0, 7));
            end
            case (rr_mode[c])
                1:       req_rready[c] = tog;
                2:       req_rready[c] = 1'($urandom_range(0, 1));
                default: req_rready[c] = 1'b1;
            endcase
        end
        pack_inputs();
    endtask

    task automatic cycle();
        @(negedge system_clk);
        sample_and_check();
        @(posedge system_clk);
        #1;
        drive_next();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic run_quiet(input int bound, input string nm);
        int n;
        n = 0;
        while ((|cl_pending || txn_active) && n < bound) begin
            cycle();
            n++;
        end
        if (n >= bound) bound_expired(nm);
    endtask

    task automatic check_order(input string nm, input int n, input int o0, input int o1,
                               input int o2, input int o3);
        int exp_o[4];
        exp_o = '{o0, o1, o2, o3};
        chk($sformatf("%s count", nm), glog.size(), n);
        for (int k = 0; k < n && k < glog.size(); k++) begin
            chk($sformatf("%s grant%0d", nm, k), glog[k], exp_o[k]);
        end
    endtask

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 len;
        int                 n;
        int                 o0, o1, o2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        rst = 1'b1;
        cl_pending = '0; req_rready = '0; tog = 0; rand_on = 0; rgap = 0;
        ar_stall = 0; err_beat = 0; issued = 0; dut_bursts = 0; obs_ar_wait = 0;
        s_state = 0; s_beat = 0; s_wait = 0;
        for (int c = 0; c < NUM_REQ; c++) begin
            cl_addr[c] = '0; cl_len[c] = '0; cl_rereq[c] = 0; rr_mode[c] = 0; dlv[c] = 0;
        end
        m00_axi_arready = 0; m00_axi_rvalid = 0; m00_axi_rlast = 0;
        m00_axi_rresp = 0; m00_axi_rdata = '0;
        pack_inputs();

        // Pointer after each row follows from the previous row, starting at 0 after reset.
        vecs[0] = '{mask: 3'b010, len: 1, n: 1, o0: 1, o1: -1, o2: -1};
        vecs[1] = '{mask: 3'b111, len: 0, n: 3, o0: 2, o1: 0,  o2: 1};
        vecs[2] = '{mask: 3'b011, len: 2, n: 2, o0: 0, o1: 1,  o2: -1};
        vecs[3] = '{mask: 3'b001, len: 3, n: 1, o0: 0, o1: -1, o2: -1};
        vecs[4] = '{mask: 3'b101, len: 0, n: 2, o0: 2, o1: 0,  o2: -1};
        vecs[5] = '{mask: 3'b110, len: 1, n: 2, o0: 1, o1: 2,  o2: -1};
        vecs[6] = '{mask: 3'b111, len: 2, n: 3, o0: 0, o1: 1,  o2: 2};

        // Reset state, with garbage on the slave data bus
        do_reset();
        chk("rst req_rdata", req_rdata, 0);
        chk("rst req_rlast", req_rlast, 0);
        chk("rst arvalid", m00_axi_arvalid, 0);
        chk("rst araddr", m00_axi_araddr, 0);
        chk("rst arlen", m00_axi_arlen, 0);
        chk("rst busy", busy, 0);
        chk("rst beat_cnt", beat_cnt, 0);

        // Single request from the weight loader
        glog.delete();
        new_req(REQ_WEIGHT, 32'h0000_1000, 3);
        cycle();
        chk("single arvalid latency", m00_axi_arvalid, 1);
        chk("single araddr", m00_axi_araddr, 32'h0000_1000);
        chk("single arlen", m00_axi_arlen, 3);
        run_quiet(100, "single");
        chk("single busy after", busy, 0);
        chk("single beats c1", dlv[1], 4);
        chk("single beats c0", dlv[0], 0);
        chk("single beats c2", dlv[2], 0);
        check_order("single", 1, REQ_WEIGHT, 0, 0, 0);

        // Table of simultaneous request patterns
        do_reset();
        for (int v = 0; v < 7; v++) begin
            glog.delete();
            for (int c = 0; c < NUM_REQ; c++) begin
                if (vecs[v].mask[c]) new_req(c, 32'h0010_0000 * (v + 1) + 32'h400 * c, vecs[v].len);
            end
            run_quiet(200, $sformatf("vec%0d", v));
            check_order($sformatf("vec%0d", v), vecs[v].n, vecs[v].o0, vecs[v].o1, vecs[v].o2, 0);
        end

        // Client 0 re-requests immediately and must yield to 1 and 2
        do_reset();
        glog.delete();
        cl_rereq[REQ_FEATURE] = 1;
        for (int c = 0; c < NUM_REQ; c++) new_req(c, 32'h0200_0000 + 32'h40 * c, 1);
        run_quiet(300, "rereq");
        check_order("rereq", 4, 0, 1, 2, 0);

        // Backpressure on client 2 over an 8-beat burst
        dlv[2] = 0;
        rr_mode[REQ_PARAM] = 1;
        new_req(REQ_PARAM, 32'h0300_0000, 7);
        run_quiet(200, "bp");
        chk("bp beat_cnt", beat_cnt, 8);
        chk("bp beats c2", dlv[2], 8);
        rr_mode[REQ_PARAM] = 0;

        // Slave stalls AR for 5 cycles; client drops arvalid after the grant is latched
        ar_stall = 5;
        obs_ar_wait = 0;
        new_req(REQ_FEATURE, 32'h0400_0040, 1);
        cycle();
        cl_pending[REQ_FEATURE] = 1'b0;
        pack_inputs();
        run_quiet(200, "stall");
        chk("stall cycles", obs_ar_wait, 5);
        ar_stall = 0;

        // Error response on beat 2 of 4 is sticky until reset
        err_beat = 2;
        new_req(REQ_WEIGHT, 32'h0500_0000, 3);
        run_quiet(200, "rresp");
        chk("rresp set", rresp_err, 1);
        err_beat = 0;
        new_req(REQ_PARAM, 32'h0500_1000, 1);
        run_quiet(200, "rresp hold");
        chk("rresp held", rresp_err, 1);
        do_reset();
        chk("rresp cleared", rresp_err, 0);

        // Reset in the middle of an 8-beat burst after moving the pointer off 0
        new_req(REQ_WEIGHT, 32'h0600_0000, 0);
        run_quiet(100, "pre-rst");
        new_req(REQ_FEATURE, 32'h0600_1000, 7);
        begin
            int n;
            n = 0;
            while (!(ar_done && mbeats == 2) && n < 100) begin
                cycle();
                n++;
            end
            if (n >= 100) bound_expired("mid-burst wait");
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst rready", m00_axi_rready, 0);
        chk("midrst arvalid", m00_axi_arvalid, 0);
        chk("midrst rvalid", req_rvalid, 0);
        chk("midrst beat_cnt", beat_cnt, 0);
        glog.delete();
        new_req(REQ_FEATURE, 32'h0700_0000, 2);
        new_req(REQ_PARAM, 32'h0700_1000, 1);
        run_quiet(200, "post-rst");
        check_order("post-rst", 2, REQ_FEATURE, REQ_PARAM, 0, 0);

        // Random traffic against the reference
        issued = 0;
        dut_bursts = 0;
        rgap = 1;
        for (int c = 0; c < NUM_REQ; c++) rr_mode[c] = 2;
        rand_on = 1;
        repeat (3000) cycle();
        rand_on = 0;
        run_quiet(2000, "random drain");
        chk("random all served", dut_bursts, issued);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the accelerator's single m00 AXI4 read channel (AR/R, 512-bit data) among NUM_REQ internal read clients: feature loader, weight loader and parameter/bias loader.
- Grants are round-robin, one burst at a time. The grant is held from AR acceptance until the final R beat (rlast) is delivered.
- Sits between the accelerator control datapath and the m00_axi_ar*/r* ports of the top level.

Parameters:
- NUM_REQ, 3, number of read clients (index 0 = feature, 1 = weight, 2 = param).
- ADDR_W, 32, AXI address width.
- DATA_W, 512, AXI data width.
- LEN_W, 8, AXI burst length field width.

Ports:
- system_clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_araddr  in  NUM_REQ*ADDR_W  packed client addresses (client i at bits [i*ADDR_W +: ADDR_W]).
- req_arlen  in  NUM_REQ*LEN_W  packed client burst lengths (beats-1).
- req_arvalid  in  NUM_REQ  client read-request valid.
- req_arready  out  NUM_REQ  client request accepted (one-hot pulse).
- req_rdata  out  DATA_W  read data broadcast to all clients.
- req_rvalid  out  NUM_REQ  one-hot data valid for the granted client.
- req_rlast  out  1  last beat of the current burst.
- req_rready  in  NUM_REQ  client data ready.
- m00_axi_araddr  out  ADDR_W  master read address.
- m00_axi_arlen  out  LEN_W  master burst length.
- m00_axi_arsize  out  3  constant 3'd6 (64 bytes).
- m00_axi_arburst  out  2  constant 2'b01 (INCR).
- m00_axi_arvalid  out  1  master address valid.
- m00_axi_arready  in  1  slave address ready.
- m00_axi_rdata  in  DATA_W  slave data.
- m00_axi_rresp  in  2  slave response.
- m00_axi_rlast  in  1  slave last beat.
- m00_axi_rvalid  in  1  slave data valid.
- m00_axi_rready  out  1  master data ready.
- busy  out  1  high in any state other than IDLE.
- rresp_err  out  1  sticky flag: some beat returned rresp != 0.
- beat_cnt  out  LEN_W+1  beats delivered in the current burst (debug).

Behaviour:
- Reset (rst high at a clock edge) forces the following, with no partial-burst recovery required:
  - state to IDLE and the round-robin pointer to 0;
  - all outputs to 0, except the constants arsize/arburst;
  - rresp_err and beat_cnt to 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If any req_arvalid is set, choose the first requester at or after the pointer (circular order).
  - Latch its index, address and length into registers; go to ADDR next cycle.
  - Grant decision latency is 1 cycle from req_arvalid to m00_axi_arvalid.
- ADDR:
  - m00_axi_arvalid = 1, driven from the latched registers, stable until handshake.
  - On arvalid & arready: pulse req_arready[grant] for exactly that cycle, load beat_cnt = 0, go to DATA.
  - Clients must hold araddr/arlen/arvalid until req_arready. A client that drops arvalid before that is a protocol error; the arbiter still issues the latched request.
- DATA:
  - m00_axi_rready = req_rready[grant].
  - req_rvalid = one-hot(grant) & m00_axi_rvalid.
  - req_rdata = m00_axi_rdata and req_rlast = m00_axi_rlast, combinational pass-through with zero added latency.
  - beat_cnt increments on each rvalid & rready.
  - On any accepted beat with rresp != 0, set rresp_err (cleared only by rst).
  - On an accepted beat with rlast: pointer = grant+1 (wrapping NUM_REQ-1 -> 0), go to IDLE.
- Only one burst is outstanding at a time; no AR is issued while in DATA.
- Arbitration only happens in IDLE. A request arriving during ADDR/DATA waits.
- Simultaneous requests are resolved by the circular priority from the pointer. Back-to-back requests from the same client yield to any other pending client.
- Length mismatch: if rlast arrives before beat_cnt == arlen, the burst still ends on rlast. If beat_cnt passes arlen without rlast, the block stays in DATA; no timeout.
- rdata of non-granted clients is don't-care; their rvalid stays 0.

Decomposition:
- Shared package / parameters.v constants:
  - AXI_SIZE_64B = 3'd6, AXI_BURST_INCR = 2'b01;
  - state encodings ST_IDLE/ST_ADDR/ST_DATA;
  - client indices REQ_FEATURE=0, REQ_WEIGHT=1, REQ_PARAM=2.
- One sub-module: rr_priority_pick (combinational circular first-one finder).
  - Inputs: request vector, pointer.
  - Outputs: grant index and found flag.
  - Reused later by the write-side arbiter.

Test Plan:
- Single request: client 1 requests addr 0x0000_1000, arlen 3 -> arvalid one cycle later with that address/len, req_arready[1] pulses on handshake, 4 beats reach client 1 only, rlast on beat 4, busy low the cycle after.
- All three request simultaneously at reset pointer -> bursts issued in order 0, 1, 2. Client 0 re-requesting immediately after its burst is served after 1 and 2.
- Backpressure: req_rready[2] toggles 1-0-1-0 during an 8-beat burst -> m00_axi_rready mirrors it, beat_cnt ends at 8, no beats lost or duplicated (compare against the axi_ram model contents).
- Slave arready held low 5 cycles -> arvalid, araddr and arlen stay stable for all 5 cycles; no req_arready until the handshake.
- rresp = 2'b10 on beat 2 of 4 -> rresp_err set and held through later bursts until rst.
- rst asserted mid-DATA (beat 2 of 8) -> next cycle: IDLE, rready/arvalid/req_rvalid all 0, pointer 0. A fresh request after rst completes normally.
